// File: rtl/branch_predictor_pkg.sv
// Shared types and defaults for the fetch-stage branch predictor.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
package branch_predictor_pkg;

   localparam int BP_PC_W    = 9;
   localparam int BP_ENTRIES = 16;
   localparam int BP_CNT_W   = 2;
   localparam int BP_STAT_W  = 32;
   localparam int BP_IDX_W   = $clog2(BP_ENTRIES);
   localparam int BP_TAG_W   = BP_PC_W - BP_IDX_W - 2;

   // One BTB line at the default geometry
   typedef struct packed {
      logic                valid;
      logic [BP_TAG_W-1:0] tag;
      logic [BP_PC_W-1:0]  target;
      logic [BP_CNT_W-1:0] cnt;
      logic                jmp;
   } btb_entry_t;

   // Prediction carried down IF/ID and ID/EX with the instruction
   typedef struct packed {
      logic [BP_PC_W-1:0] pc;
      logic               pred_taken;
      logic [BP_PC_W-1:0] pred_target;
   } pipe_pred_t;

   // Word-aligned index bits; pc[1:0] never participate
   function automatic logic [BP_IDX_W-1:0] btb_idx(input logic [BP_PC_W-1:0] pc);
      return pc[BP_IDX_W+1:2];
   endfunction

   // Remaining upper bits form the tag
   function automatic logic [BP_TAG_W-1:0] btb_tag(input logic [BP_PC_W-1:0] pc);
      return pc[BP_PC_W-1:BP_IDX_W+2];
   endfunction

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// Saturating up/down counter next-state logic for one BTB line.
// Latency: combinational, zero cycles.
// Backpressure: none; result is consumed by the table write.
module sat_counter #(
   parameter int CNT_W = 2
) (
   input  logic [CNT_W-1:0] cnt,
   input  logic             up,
   output logic [CNT_W-1:0] cnt_next
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Step toward taken on up, toward not-taken otherwise, clamping at both ends
   always_comb begin
      cnt_next = cnt;
      if (up) begin
         if (cnt != CNT_MAX) cnt_next = cnt + CNT_W'(1);
      end else begin
         if (cnt != '0) cnt_next = cnt - CNT_W'(1);
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with saturating counters: fetch lookup, EX update, redirect, statistics.
// Latency: lookup and mispredict are combinational; table/stat updates land on the next clk edge.
// Backpressure: none; one lookup and at most one update are accepted every cycle.
module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int PC_W    = BP_PC_W,
   parameter int ENTRIES = BP_ENTRIES,
   parameter int CNT_W   = BP_CNT_W,
   parameter int STAT_W  = BP_STAT_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [PC_W-1:0]   fetch_pc,
   output logic              pred_taken,
   output logic [PC_W-1:0]   pred_target,
   output logic              pred_hit,
   input  logic              upd_valid,
   input  logic [PC_W-1:0]   upd_pc,
   input  logic              upd_taken,
   input  logic [PC_W-1:0]   upd_target,
   input  logic              upd_is_jump,
   input  logic              upd_pred_taken,
   input  logic [PC_W-1:0]   upd_pred_target,
   input  logic              flush_all,
   output logic              mispredict,
   output logic [PC_W-1:0]   redirect_pc,
   output logic [STAT_W-1:0] stat_branches,
   output logic [STAT_W-1:0] stat_mispredicts
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = PC_W - IDX_W - 2;
   localparam logic [CNT_W-1:0] CNT_WEAK_T = CNT_W'(1) << (CNT_W - 1);

   // Line layout follows the package btb_entry_t, resized to this instance's geometry
   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
      logic [PC_W-1:0]  target;
      logic [CNT_W-1:0] cnt;
      logic             jmp;
   } entry_t;

   entry_t tbl [ENTRIES];

   logic [IDX_W-1:0] f_idx, u_idx;
   logic [TAG_W-1:0] f_tag, u_tag;
   entry_t           f_ent, u_ent;
   logic             u_hit;
   logic [CNT_W-1:0] u_cnt_next;
   logic             unused_low_bits;

   assign f_idx = fetch_pc[IDX_W+1:2];
   assign f_tag = fetch_pc[PC_W-1:IDX_W+2];
   assign u_idx = upd_pc[IDX_W+1:2];
   assign u_tag = upd_pc[PC_W-1:IDX_W+2];
   assign f_ent = tbl[f_idx];
   assign u_ent = tbl[u_idx];
   assign u_hit = u_ent.valid && (u_ent.tag == u_tag);
   assign unused_low_bits = ^{fetch_pc[1:0], upd_pc[1:0]};

   sat_counter #(.CNT_W(CNT_W)) u_sat (
      .cnt      (u_ent.cnt),
      .up       (upd_taken),
      .cnt_next (u_cnt_next)
   );

   // Fetch lookup: jumps predict taken regardless of counter state
   always_comb begin
      pred_hit    = f_ent.valid && (f_ent.tag == f_tag);
      pred_taken  = pred_hit && (f_ent.jmp || f_ent.cnt[CNT_W-1]);
      pred_target = pred_taken ? f_ent.target : fetch_pc + PC_W'(4);
   end

   // Resolution check: wrong direction, or right direction with wrong target
   always_comb begin
      mispredict  = upd_valid && ((upd_taken != upd_pred_taken) ||
                    (upd_taken && upd_pred_taken && (upd_target != upd_pred_target)));
      redirect_pc = upd_taken ? upd_target : upd_pc + PC_W'(4);
   end

   // Table maintenance; flush beats a same-cycle allocation, stats count regardless
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) tbl[i] <= '0;
         stat_branches    <= '0;
         stat_mispredicts <= '0;
      end else begin
         if (upd_valid)  stat_branches    <= stat_branches + STAT_W'(1);
         if (mispredict) stat_mispredicts <= stat_mispredicts + STAT_W'(1);
         if (flush_all) begin
            for (int i = 0; i < ENTRIES; i++) tbl[i].valid <= 1'b0;
         end else if (upd_valid) begin
            if (u_hit) begin
               tbl[u_idx].cnt <= u_cnt_next;
               if (upd_taken) begin
                  tbl[u_idx].target <= upd_target;
                  tbl[u_idx].jmp    <= upd_is_jump;
               end
            end else if (upd_taken) begin
               tbl[u_idx].valid  <= 1'b1;
               tbl[u_idx].tag    <= u_tag;
               tbl[u_idx].target <= upd_target;
               tbl[u_idx].jmp    <= upd_is_jump;
               tbl[u_idx].cnt    <= CNT_WEAK_T;
            end
         end
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed-vector bench for branch_predictor with a queue-based scoreboard.
// Latency: expectations are popped on the falling edge of the cycle they were issued in.
// Backpressure: n/a.
module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        reset;
   logic [8:0]  fetch_pc;
   logic        pred_taken, pred_hit;
   logic [8:0]  pred_target;
   logic        upd_valid, upd_taken, upd_is_jump, upd_pred_taken, flush_all;
   logic [8:0]  upd_pc, upd_target, upd_pred_target;
   logic        mispredict;
   logic [8:0]  redirect_pc;
   logic [31:0] stat_branches, stat_mispredicts;

   always #5 clk = ~clk;

   branch_predictor #(.PC_W(9), .ENTRIES(16), .CNT_W(2), .STAT_W(32)) dut (
      .clk              (clk),
      .reset            (reset),
      .fetch_pc         (fetch_pc),
      .pred_taken       (pred_taken),
      .pred_target      (pred_target),
      .pred_hit         (pred_hit),
      .upd_valid        (upd_valid),
      .upd_pc           (upd_pc),
      .upd_taken        (upd_taken),
      .upd_target       (upd_target),
      .upd_is_jump      (upd_is_jump),
      .upd_pred_taken   (upd_pred_taken),
      .upd_pred_target  (upd_pred_target),
      .flush_all        (flush_all),
      .mispredict       (mispredict),
      .redirect_pc      (redirect_pc),
      .stat_branches    (stat_branches),
      .stat_mispredicts (stat_mispredicts)
   );

   typedef struct {
      int          step;
      logic        hit;
      logic        tk;
      logic [8:0]  tgt;
      logic        mis;
      logic        chk_redir;
      logic [8:0]  redir;
      logic [31:0] sb;
      logic [31:0] sm;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input int step, input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL step %0d %s: got 0x%0h, expected 0x%0h", step, name, act, req);
      end
   endtask

   // Monitor: every expectation describes the outputs of exactly one cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(e.step, "pred_hit",         32'(pred_hit),    32'(e.hit));
            chk(e.step, "pred_taken",       32'(pred_taken),  32'(e.tk));
            chk(e.step, "pred_target",      32'(pred_target), 32'(e.tgt));
            chk(e.step, "mispredict",       32'(mispredict),  32'(e.mis));
            if (e.chk_redir) chk(e.step, "redirect_pc", 32'(redirect_pc), 32'(e.redir));
            chk(e.step, "stat_branches",    stat_branches,    e.sb);
            chk(e.step, "stat_mispredicts", stat_mispredicts, e.sm);
         end
      end
   end

   int step_no = 0;

   // Drive one cycle of inputs and post the hand-computed response for it
   task automatic step(input logic [8:0] fpc, input logic uv, input logic [8:0] upc, input logic ut,
                       input logic [8:0] utgt, input logic ujmp, input logic upt, input logic [8:0] uptgt,
                       input logic fl, input logic e_hit, input logic e_tk, input logic [8:0] e_tgt,
                       input logic e_mis, input logic [8:0] e_redir, input logic [31:0] e_sb,
                       input logic [31:0] e_sm);
      exp_t e;
      @(posedge clk);
      #1;
      fetch_pc = fpc; upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utgt;
      upd_is_jump = ujmp; upd_pred_taken = upt; upd_pred_target = uptgt; flush_all = fl;
      step_no++;
      e.step = step_no; e.hit = e_hit; e.tk = e_tk; e.tgt = e_tgt; e.mis = e_mis;
      e.chk_redir = uv; e.redir = e_redir; e.sb = e_sb; e.sm = e_sm;
      exp_q.push_back(e);
   endtask

   task automatic idle(input logic [8:0] fpc, input logic e_hit, input logic e_tk, input logic [8:0] e_tgt,
                       input logic [31:0] e_sb, input logic [31:0] e_sm);
      step(fpc, 0, 9'h000, 0, 9'h000, 0, 0, 9'h000, 0, e_hit, e_tk, e_tgt, 0, 9'h000, e_sb, e_sm);
   endtask

   initial begin
      reset = 1'b1; fetch_pc = '0; upd_valid = 0; upd_pc = '0; upd_taken = 0; upd_target = '0;
      upd_is_jump = 0; upd_pred_taken = 0; upd_pred_target = '0; flush_all = 0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      // fpc  uv upc    ut utgt   j pt ptgt   fl | hit tk tgt    mis redir  sb  sm
      idle(9'h010, 0, 0, 9'h014, 0, 0);
      step(9'h020, 1, 9'h020, 1, 9'h040, 0, 0, 9'h000, 0, 0, 0, 9'h024, 1, 9'h040, 0, 0);
      idle(9'h020, 1, 1, 9'h040, 1, 1);
      step(9'h020, 1, 9'h020, 0, 9'h000, 0, 1, 9'h040, 0, 1, 1, 9'h040, 1, 9'h024, 1, 1);
      step(9'h020, 1, 9'h020, 0, 9'h000, 0, 0, 9'h000, 0, 1, 0, 9'h024, 0, 9'h024, 2, 2);
      step(9'h020, 1, 9'h020, 0, 9'h000, 0, 0, 9'h000, 0, 1, 0, 9'h024, 0, 9'h024, 3, 2);
      idle(9'h020, 1, 0, 9'h024, 4, 2);
      // one taken step from a saturated 00 must land on 01 (still not taken)
      step(9'h020, 1, 9'h020, 1, 9'h040, 0, 0, 9'h000, 0, 1, 0, 9'h024, 1, 9'h040, 4, 2);
      idle(9'h020, 1, 0, 9'h024, 5, 3);
      // alias at index 8 with a different tag evicts the 0x020 line
      step(9'h060, 1, 9'h060, 1, 9'h0A0, 0, 0, 9'h000, 0, 0, 0, 9'h064, 1, 9'h0A0, 5, 3);
      idle(9'h020, 0, 0, 9'h024, 6, 4);
      idle(9'h060, 1, 1, 9'h0A0, 6, 4);
      step(9'h060, 1, 9'h060, 1, 9'h0A0, 0, 1, 9'h0A0, 0, 1, 1, 9'h0A0, 0, 9'h0A0, 6, 4);
      // right direction, wrong target; hit retargets the line
      step(9'h010, 1, 9'h060, 1, 9'h0C0, 0, 1, 9'h0A0, 0, 0, 0, 9'h014, 1, 9'h0C0, 7, 4);
      idle(9'h060, 1, 1, 9'h0C0, 8, 5);
      // JAL to 0x000, then drive its counter down: jump bit keeps it taken
      step(9'h100, 1, 9'h100, 1, 9'h000, 1, 0, 9'h000, 0, 0, 0, 9'h104, 1, 9'h000, 8, 5);
      step(9'h100, 1, 9'h100, 0, 9'h000, 1, 1, 9'h000, 0, 1, 1, 9'h000, 1, 9'h104, 9, 6);
      step(9'h100, 1, 9'h100, 0, 9'h000, 1, 1, 9'h000, 0, 1, 1, 9'h000, 1, 9'h104, 10, 7);
      idle(9'h100, 1, 1, 9'h000, 11, 8);
      // top-of-space PC wraps for both fall-through paths
      step(9'h1FC, 1, 9'h1FC, 0, 9'h000, 0, 0, 9'h000, 0, 0, 0, 9'h000, 0, 9'h000, 11, 8);
      idle(9'h1FC, 0, 0, 9'h000, 12, 8);
      // flush with a same-cycle taken update: nothing allocated, stats still count
      step(9'h080, 1, 9'h080, 1, 9'h0F0, 0, 0, 9'h000, 1, 0, 0, 9'h084, 1, 9'h0F0, 12, 8);
      idle(9'h080, 0, 0, 9'h084, 13, 9);
      idle(9'h100, 0, 0, 9'h104, 13, 9);
      idle(9'h060, 0, 0, 9'h064, 13, 9);
      // refill index 8, then reset with an update pending: both must vanish
      step(9'h020, 1, 9'h020, 1, 9'h040, 0, 1, 9'h040, 0, 0, 0, 9'h024, 0, 9'h040, 13, 9);
      idle(9'h020, 1, 1, 9'h040, 14, 9);
      @(posedge clk);
      #1;
      reset = 1'b1; upd_valid = 1; upd_pc = 9'h060; upd_taken = 1; upd_target = 9'h0A0;
      upd_pred_taken = 0;
      @(posedge clk);
      #1;
      reset = 1'b0; upd_valid = 0; upd_taken = 0;
      step_no++;
      begin
         exp_t e;
         e.step = step_no; e.hit = 0; e.tk = 0; e.tgt = 9'h024; e.mis = 0;
         e.chk_redir = 0; e.redir = '0; e.sb = 0; e.sm = 0;
         fetch_pc = 9'h020;
         exp_q.push_back(e);
      end
      idle(9'h060, 0, 0, 9'h064, 0, 0);
      // bounded drain of the scoreboard
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      @(posedge clk);
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Dynamic branch predictor for the fetch stage of the 5-stage RV32I pipeline; replaces the static predict-not-taken scheme, in which every taken branch or jump flushes IF/ID and ID/EX.
- The fetch PC is looked up each cycle in a direct-mapped branch target buffer (BTB) with saturating counters; a hit predicts the next PC.
- The EX stage returns the resolved outcome; the block updates the table, flags mispredictions, supplies the redirect PC and keeps statistics counters.

Parameters:
- PC_W, 9, PC / target width in bits.
- ENTRIES, 16, BTB entries; power of two, ≥2.
- CNT_W, 2, saturating-counter width, ≥1.
- STAT_W, 32, statistics counter width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- fetch_pc  in  PC_W  current IF PC
- pred_taken  out  1  prediction for fetch_pc
- pred_target  out  PC_W  predicted next PC; fetch_pc+4 when not taken
- pred_hit  out  1  BTB tag hit for fetch_pc
- upd_valid  in  1  EX holds a resolved branch/jump this cycle
- upd_pc  in  PC_W  PC of the resolved instruction
- upd_taken  in  1  actual direction
- upd_target  in  PC_W  actual target
- upd_is_jump  in  1  JAL/JALR (unconditional)
- upd_pred_taken  in  1  prediction carried down the pipe with the instruction
- upd_pred_target  in  PC_W  predicted target carried down the pipe
- flush_all  in  1  invalidate the whole table
- mispredict  out  1  redirect required
- redirect_pc  out  PC_W  correct next PC
- stat_branches  out  STAT_W  resolved branches/jumps
- stat_mispredicts  out  STAT_W  mispredictions

Behaviour:
- Field split: IDX_W = log2(ENTRIES); index = pc[IDX_W+1:2]; tag = pc[PC_W-1:IDX_W+2]. pc[1:0] is ignored.
- Entry fields: valid, tag, target[PC_W], cnt[CNT_W], jmp.
- Lookup is combinational, zero latency:
  - pred_hit = valid & tag match.
  - pred_taken = pred_hit & (jmp | cnt MSB).
  - pred_target = pred_taken ? target : fetch_pc+4, mod 2^PC_W (wraps).
- Update is registered and takes effect on the clk edge after upd_valid. A lookup of the same index in that cycle sees the old contents (no bypass).
- Update on hit (valid & tag match at the upd_pc index):
  - taken: cnt saturating-increments, max 2^CNT_W-1; target <= upd_target; jmp <= upd_is_jump.
  - not-taken: cnt saturating-decrements, min 0.
- Update on miss:
  - taken: allocate and overwrite any occupant; valid=1, tag, target, jmp=upd_is_jump, cnt = weakly taken (MSB=1, rest 0).
  - not-taken: no change.
- Mispredict logic is combinational from the upd_* inputs:
  - mispredict = upd_valid & ((upd_taken != upd_pred_taken) | (upd_taken & upd_pred_taken & upd_target != upd_pred_target)).
  - redirect_pc = upd_taken ? upd_target : upd_pc+4 (wraps).
  - mispredict=0 when upd_valid=0.
- Statistics:
  - stat_branches increments on each upd_valid cycle; stat_mispredicts increments on each mispredict cycle.
  - Both wrap at 2^STAT_W.
  - flush_all does not clear them.
- flush_all: on the next edge all valid bits are cleared. flush_all and upd_valid in the same cycle: flush wins and no allocation happens; statistics still count.
- Reset: all valid bits, counters and targets are cleared; stat_* = 0.
  - With no update pending, outputs are then pred_hit=0, pred_taken=0, pred_target=fetch_pc+4, mispredict=0.
  - Reset mid-operation discards the pending update.

Decomposition:
- Shared package gets typedef btb_entry_t (valid, tag, target, cnt, jmp) and the field-split helper functions (idx, tag).
- The pipeline-register structs gain pred_taken / pred_target fields so the prediction travels with the instruction.
- One natural sub-module: sat_counter (CNT_W parameter; inc/dec with saturation), instantiated per entry or used as a function.

Test Plan:
- Reset, fetch_pc=0x010 -> pred_hit=0, pred_taken=0, pred_target=0x014; stat_*=0.
- Update upd_pc=0x020, taken, target 0x040, pred_taken=0 -> mispredict=1, redirect_pc=0x040. Next cycle, fetch_pc=0x020 -> hit, taken, target 0x040.
- Three not-taken updates at 0x020 -> cnt 10→01→00→00 (saturates). Lookup -> pred_taken=0, pred_target=0x024. Counter is at 00 after the second update.
- Aliasing, ENTRIES=16: taken at 0x020, then taken at 0x060 (same index, different tag) -> 0x020 lookup misses; 0x060 hits with its own target.
- JAL at 0x100 (upd_is_jump=1, target 0x000, with wrap) -> always predicted taken regardless of cnt. A 9-bit PC at 0x1FC not taken gives redirect_pc=0x000.
- flush_all together with a taken update at 0x080 -> no entry allocated; all lookups miss; stat_branches increments by 1.
